// File: rtl/apb_master_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_bridge_pkg
// Shared types and constants for the APB master bridge.
//   apb_state_e   : bridge FSM states
//   UART_START    : first address of the peripheral APB window (default WIN_START)
//   DEBUG_END     : last address of the peripheral APB window (default WIN_END)
//   APB_WORD_MASK : clears the byte offset so every APB access is word aligned
//   in_window()   : inclusive address window compare
// -----------------------------------------------------------------------------
package apb_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP,
      ERR
   } apb_state_e;

   localparam logic [31:0] UART_START    = 32'h1A10_0000;
   localparam logic [31:0] DEBUG_END     = 32'h1A11_7FFF;
   localparam logic [31:0] APB_WORD_MASK = 32'hFFFF_FFFC;

   // Both bounds are inclusive.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
// APB3 bus bundle between the bridge (master) and the peripheral bus (slave).
//   paddr, pwdata, pwrite, psel, penable : driven by the master
//   prdata, pready, pslverr              : driven by the slave
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic                  pwrite;
   logic                  psel;
   logic                  penable;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output paddr, pwdata, pwrite, psel, penable,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, pwdata, pwrite, psel, penable,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Turns the core's single-outstanding req/gnt/rvalid data port into APB3
// master transfers. Requests outside [WIN_START, WIN_END] and partial-word
// writes are answered with an error response without touching the bus.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   data_req_i      : core request
//   data_addr_i     : byte address (low two bits ignored)
//   data_we_i       : 1 = write
//   data_be_i       : byte enables, writes must be full word
//   data_wdata_i    : write data
//   data_gnt_o      : request accepted (combinational, IDLE only)
//   data_rvalid_o   : one-cycle response strobe
//   data_rdata_o    : read data, valid with rvalid
//   data_err_o      : error flag, valid with rvalid
//   apb             : APB3 master modport (paddr/pwdata/pwrite/psel/penable out,
//                     prdata/pready/pslverr in)
//
// Optional build macro:
//   APB_TIMEOUT_EN  : abort an ACCESS phase with an error after TIMEOUT_CYCLES
//                     cycles of pready = 0. Undefined: ACCESS waits forever.
// -----------------------------------------------------------------------------
module apb_master_bridge
   import apb_bridge_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] WIN_START      = UART_START,
   parameter logic [ADDR_WIDTH-1:0] WIN_END        = DEBUG_END,
   parameter int unsigned           TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    data_req_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic                    data_err_o,

   apb_master_bridge_if.master     apb
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef APB_TIMEOUT_EN
   localparam int unsigned         TO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_CNT_W-1:0] TO_LAST  = TO_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [TO_CNT_W-1:0] r_cnt;
`endif

   apb_state_e            r_state;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_pwrite;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_rvalid;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_gnt;
   logic [ADDR_WIDTH-1:0] w_addr_aligned;
   logic                  w_req_bad;

   // Gated by rst so a request is never acknowledged on an edge that discards it.
   assign w_gnt          = data_req_i && (r_state == IDLE) && !rst;
   assign w_addr_aligned = data_addr_i & APB_WORD_MASK[ADDR_WIDTH-1:0];
   assign w_req_bad      = !in_window(w_addr_aligned, WIN_START, WIN_END) ||
                           (data_we_i && !(&data_be_i));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pwrite  <= 1'b0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_rvalid  <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
`ifdef APB_TIMEOUT_EN
         r_cnt     <= '0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_gnt) begin
                  r_paddr  <= w_addr_aligned;
                  r_pwrite <= data_we_i;
                  r_pwdata <= data_wdata_i;
                  if (w_req_bad) begin
                     r_state  <= ERR;
                     r_rvalid <= 1'b1;
                     r_err    <= 1'b1;
                     r_rdata  <= '0;
                  end else begin
                     r_state <= SETUP;
                     r_psel  <= 1'b1;
`ifdef APB_TIMEOUT_EN
                     r_cnt   <= '0;
`endif
                  end
               end
            end

            SETUP: begin
               r_state   <= ACCESS;
               r_penable <= 1'b1;
            end

            ACCESS: begin
               // pready is checked first so a completion on the timeout cycle wins.
               if (apb.pready) begin
                  r_state   <= RESP;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_err     <= apb.pslverr;
                  if (!r_pwrite) begin
                     r_rdata <= apb.prdata;
                  end
               end
`ifdef APB_TIMEOUT_EN
               else if (r_cnt == TO_LAST) begin
                  r_state   <= ERR;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_err     <= 1'b1;
                  r_rdata   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end

            RESP, ERR: begin
               r_state  <= IDLE;
               r_rvalid <= 1'b0;
               r_err    <= 1'b0;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign data_gnt_o    = w_gnt;
   assign data_rvalid_o = r_rvalid;
   assign data_err_o    = r_err;
   assign data_rdata_o  = r_rdata;

   assign apb.paddr     = r_paddr;
   assign apb.pwdata    = r_pwdata;
   assign apb.pwrite    = r_pwrite;
   assign apb.psel      = r_psel;
   assign apb.penable   = r_penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
// Directed bench for apb_master_bridge: a table of single transfers against a
// programmable-wait APB slave, plus hand-written back-to-back, mid-transfer
// reset and ACCESS-timeout sequences (timeout leg selected by APB_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      int          exp_rv;     // cycle of rvalid, grant cycle = 0
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic        exp_apb;    // an APB transfer is expected
      logic [31:0] exp_paddr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   always #5 clk = ~clk;

   apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_master_bridge #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .WIN_START      (32'h1A10_0000),
      .WIN_END        (32'h1A11_7FFF),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_req_i    (req),
      .data_addr_i   (addr),
      .data_we_i     (we),
      .data_be_i     (be),
      .data_wdata_i  (wdata),
      .data_gnt_o    (gnt),
      .data_rvalid_o (rvalid),
      .data_rdata_o  (rdata),
      .data_err_o    (err),
      .apb           (bus.master)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Slave model: pready after s_waits wait cycles in each ACCESS phase.
   int          s_waits  = 0;
   logic [31:0] s_prdata = '0;
   logic        s_slverr = 1'b0;
   int          s_cnt    = 0;
   int          s_acc    = 0;
   bit          s_seen   = 0;
   bit          s_unstable = 0;
   logic [31:0] s_paddr, s_pwdata;
   logic        s_pwrite;

   initial begin
      bus.pready  = 1'b0;
      bus.prdata  = '0;
      bus.pslverr = 1'b0;
   end

   always @(negedge clk) begin
      if (bus.psel) begin
         if (!s_seen) begin
            s_seen   = 1;
            s_paddr  = bus.paddr;
            s_pwdata = bus.pwdata;
            s_pwrite = bus.pwrite;
         end else if (bus.paddr !== s_paddr || bus.pwdata !== s_pwdata ||
                      bus.pwrite !== s_pwrite) begin
            s_unstable = 1;
         end
      end
      bus.prdata  = s_prdata;
      bus.pslverr = s_slverr;
      if (bus.psel && bus.penable) begin
         bus.pready = (s_cnt == s_waits);
         s_cnt++;
         s_acc++;
      end else begin
         bus.pready = 1'b0;
         s_cnt      = 0;
      end
   end

   // Results of the last run_txn.
   int          o_gnt_wait, o_rv, o_psel1, o_pen1;
   logic        o_err, o_rv_next;
   logic [31:0] o_rdata;
   bit          o_leak;

   task automatic run_txn(input vec_t v);
      int k;
      s_waits  = v.waits;
      s_prdata = v.prdata;
      s_slverr = v.slverr;
      @(negedge clk);
      s_acc = 0; s_seen = 0; s_unstable = 0;
      o_rv = -1; o_psel1 = -1; o_pen1 = -1; o_leak = 0;
      o_err = 1'bx; o_rdata = 'x; o_rv_next = 1'bx;
      req = 1'b1; addr = v.addr; we = v.we; be = v.be; wdata = v.wdata;
      #1;
      k = 0;
      while (!gnt && k < 10) begin
         @(negedge clk);
         #1;
         k++;
      end
      o_gnt_wait = k;
      @(negedge clk);
      req = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         if (c > 1) @(negedge clk);
         if (bus.psel && o_psel1 < 0) o_psel1 = c;
         if (bus.penable && o_pen1 < 0) o_pen1 = c;
         if (err && !rvalid) o_leak = 1;
         if (rvalid) begin
            o_rv    = c;
            o_err   = err;
            o_rdata = rdata;
            break;
         end
      end
      @(negedge clk);
      o_rv_next = rvalid;
      if (err) o_leak = 1;
   endtask

   task automatic check_txn(input string tag, input vec_t v);
      chk({tag, "_gnt"},     32'(o_gnt_wait), 32'd0);
      chk({tag, "_rv_cyc"},  32'(o_rv),       32'(v.exp_rv));
      chk({tag, "_err"},     {31'd0, o_err},  {31'd0, v.exp_err});
      chk({tag, "_rdata"},   o_rdata,         v.exp_rdata);
      chk({tag, "_rv_1cyc"}, {31'd0, o_rv_next}, 32'd0);
      chk({tag, "_errleak"}, {31'd0, o_leak},    32'd0);
      if (v.exp_apb) begin
         chk({tag, "_psel_cyc"}, 32'(o_psel1), 32'd1);
         chk({tag, "_pen_cyc"},  32'(o_pen1),  32'd2);
         chk({tag, "_paddr"},    s_paddr,      v.exp_paddr);
         chk({tag, "_pwrite"},   {31'd0, s_pwrite}, {31'd0, v.we});
         if (v.we) chk({tag, "_pwdata"}, s_pwdata, v.wdata);
         chk({tag, "_stable"},   {31'd0, s_unstable}, 32'd0);
      end else begin
         chk({tag, "_no_psel"},  {31'd0, s_seen}, 32'd0);
      end
   endtask

   vec_t vecs[10];
   vec_t v;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g1, g2, r1, r2;
      logic [31:0] r2_data;
      bit saw_rv;

      //          addr          we    be     wdata         waits prdata        slv  rv err  rdata         apb  paddr
      vecs[0] = '{32'h1A10_1008, 1'b0, 4'hF, 32'h0,          0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h1A10_1008};
      vecs[1] = '{32'h1A10_3004, 1'b1, 4'hF, 32'h0000_00A5,  3, 32'h1234_5678, 1'b0, 6, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h1A10_3004};
      vecs[2] = '{32'h1A10_0010, 1'b0, 4'hF, 32'h0,          1, 32'h0BAD_F00D, 1'b1, 4, 1'b1, 32'h0BAD_F00D, 1'b1, 32'h1A10_0010};
      vecs[3] = '{32'h1A12_0000, 1'b0, 4'hF, 32'h0,          0, 32'h1111_1111, 1'b0, 1, 1'b1, 32'h0,         1'b0, 32'h0};
      vecs[4] = '{32'h1A10_0000, 1'b1, 4'h3, 32'hFFFF_FFFF,  0, 32'h1111_1111, 1'b0, 1, 1'b1, 32'h0,         1'b0, 32'h0};
      vecs[5] = '{32'h1A11_7FFF, 1'b0, 4'h0, 32'h0,          0, 32'hCAFE_F00D, 1'b0, 3, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h1A11_7FFC};
      vecs[6] = '{32'h1A11_8000, 1'b0, 4'hF, 32'h0,          0, 32'h2222_2222, 1'b0, 1, 1'b1, 32'h0,         1'b0, 32'h0};
      vecs[7] = '{32'h1A0F_FFFF, 1'b0, 4'hF, 32'h0,          0, 32'h3333_3333, 1'b0, 1, 1'b1, 32'h0,         1'b0, 32'h0};
      vecs[8] = '{32'h1A10_0000, 1'b0, 4'hF, 32'h0,          2, 32'h55AA_55AA, 1'b0, 5, 1'b0, 32'h55AA_55AA, 1'b1, 32'h1A10_0000};
      vecs[9] = '{32'h1A10_0007, 1'b1, 4'hF, 32'hFFFF_0000,  0, 32'h9999_9999, 1'b0, 3, 1'b0, 32'h55AA_55AA, 1'b1, 32'h1A10_0004};

      rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_psel",    {31'd0, bus.psel},    32'd0);
      chk("rst_penable", {31'd0, bus.penable}, 32'd0);
      chk("rst_pwrite",  {31'd0, bus.pwrite},  32'd0);
      chk("rst_paddr",   bus.paddr,            32'd0);
      chk("rst_pwdata",  bus.pwdata,           32'd0);
      chk("rst_rvalid",  {31'd0, rvalid},      32'd0);
      chk("rst_err",     {31'd0, err},         32'd0);
      chk("rst_rdata",   rdata,                32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_gnt_noreq", {31'd0, gnt}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i]);
         check_txn($sformatf("v%0d", i), vecs[i]);
      end

      // Back-to-back: req held high across two reads.
      s_waits = 0; s_prdata = 32'h1111_2222; s_slverr = 1'b0;
      @(negedge clk);
      g1 = -1; g2 = -1; r1 = -1; r2 = -1; r2_data = '0;
      req = 1'b1; addr = 32'h1A10_0100; we = 1'b0; be = 4'hF;
      for (int k = 0; k < 14; k++) begin
         if (k > 0) @(negedge clk);
         if (g2 >= 0) req = 1'b0;
         #1;
         if (rvalid) begin
            if (r1 < 0) r1 = k;
            else if (r2 < 0) begin r2 = k; r2_data = rdata; end
         end
         if (gnt) begin
            if (g1 < 0) g1 = k;
            else if (g2 < 0) g2 = k;
         end
      end
      chk("b2b_gnt1", 32'(g1), 32'd0);
      chk("b2b_rv1",  32'(r1), 32'd3);
      chk("b2b_gnt2", 32'(g2), 32'd4);
      chk("b2b_rv2",  32'(r2), 32'd7);
      chk("b2b_rdata2", r2_data, 32'h1111_2222);

      // Reset asserted during ACCESS with a slave that never answers.
      s_waits = 1000;
      @(negedge clk);
      req = 1'b1; addr = 32'h1A10_0200; we = 1'b0; be = 4'hF;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("rstmid_in_access", {31'd0, bus.penable}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_psel",    {31'd0, bus.psel},    32'd0);
      chk("rstmid_penable", {31'd0, bus.penable}, 32'd0);
      chk("rstmid_paddr",   bus.paddr,            32'd0);
      chk("rstmid_rvalid",  {31'd0, rvalid},      32'd0);
      rst = 1'b0;
      saw_rv = 0;
      repeat (6) begin
         @(negedge clk);
         if (rvalid || bus.psel) saw_rv = 1;
      end
      chk("rstmid_no_resp", {31'd0, saw_rv}, 32'd0);

`ifdef APB_TIMEOUT_EN
      // Slave never ready: error after 4 ACCESS cycles (cycles 2..5), rvalid at 6.
      v = '{32'h1A10_0300, 1'b0, 4'hF, 32'h0, 1000, 32'h4444_4444, 1'b0,
            6, 1'b1, 32'h0, 1'b1, 32'h1A10_0300};
      run_txn(v);
      check_txn("to_fire", v);
      chk("to_fire_acc", 32'(s_acc), 32'd4);
      // pready on the 4th ACCESS cycle beats the timeout.
      v = '{32'h1A10_0304, 1'b0, 4'hF, 32'h0, 3, 32'h7777_8888, 1'b0,
            6, 1'b0, 32'h7777_8888, 1'b1, 32'h1A10_0304};
      run_txn(v);
      check_txn("to_race", v);
      chk("to_race_acc", 32'(s_acc), 32'd4);
`else
      // No timeout logic: a long wait still completes normally.
      v = '{32'h1A10_0300, 1'b0, 4'hF, 32'h0, 10, 32'h7777_8888, 1'b0,
            13, 1'b0, 32'h7777_8888, 1'b1, 32'h1A10_0300};
      run_txn(v);
      check_txn("long_wait", v);
      chk("long_wait_acc", 32'(s_acc), 32'd11);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
